mmio_uart_fifo: RTL and testbench
=================================

# mmio_uart_fifo

Memory-mapped UART front end for the MIPS150 data-memory path. It replaces the single-byte DataInValid/DataOutReady handshake with parametrised RX and TX FIFOs, a status register, and optional error counters. It sits between the CPU's dcache-side address/data/strobe bus and the existing byte-wide UART transmitter/receiver.

## Interface
Parameters:
- `RX_DEPTH`, default 16: RX FIFO entries; power of two, ≥2.
- `TX_DEPTH`, default 16: TX FIFO entries; power of two, ≥2.
- `BASE_ADDR`, default 32'h8000_0000: base address of the register window; 16-byte aligned.

Ports:
- `clk` in 1: single clock.
- `rst` in 1: reset; asynchronous, active-high.
- `addr` in 32: CPU byte address (dcache_addr).
- `we` in 4: byte write strobes (dcache_we); any nonzero bit counts as a write.
- `re` in 1: read enable (dcache_re).
- `din` in 32: write data (dcache_din); bits [7:0] are used for TX.
- `stall` in 1: global pipeline stall; while high, no access takes effect.
- `dout` out 32: registered read data.
- `hit` out 1: combinational; addr is within [BASE_ADDR, BASE_ADDR+15].
- `rx_data` in 8 / `rx_valid` in 1: received byte from the UART receiver; accepted unconditionally.
- `tx_data` out 8 / `tx_valid` out 1 / `tx_ready` in 1: byte stream to the UART transmitter; valid/ready handshake.

## Operation
Register map (word offset; addr[1:0] ignored):
- 0x0 STATUS (R): bit0 = TX not full; bit1 = RX not empty; bits[15:8] = RX occupancy; bits[23:16] = TX free slots; other bits 0. Writes are ignored.
- 0x4 RXDATA (R): bits[7:0] = RX head byte; the read pops it. If RX is empty, the read returns 0 and does not pop.
- 0x8 TXDATA (W): pushes din[7:0]. If TX is full, the byte is dropped. Reads return 0.
- 0xC ERR (R/W): see Configuration.

Access rules:
- An access is effective only when `hit && !stall`.
- `re && we != 0` on the same address: the write takes priority and `dout` is 0.
- A pop occurs only on an effective RXDATA read.
- RX push:
  - On `rx_valid`: if RX has space, or an effective pop happens in the same cycle, push the byte.
  - Otherwise drop the byte and raise the overflow event.
- TX side:
  - `tx_valid` = TX not empty; `tx_data` = TX head.
  - Pop on `tx_valid && tx_ready`.
  - A push to a full TX FIFO succeeds if a pop happens in the same cycle.
- Occupancy counters use widths of $clog2(DEPTH)+1 bits. Pointers wrap modulo DEPTH. Full means count == DEPTH.

## Timing
- Read latency is 1 cycle: `dout` is registered from an effective read at cycle N and is valid at N+1.
  - With no effective read, `dout` holds its previous value.
  - `dout` is updated with the pre-pop RX head.
- STATUS is sampled before the same-cycle push and pop take effect.
- FIFO write-to-read latency:
  - RX: a byte pushed at N is visible in STATUS and RXDATA from N+1.
  - TX: a byte pushed at N has `tx_valid` asserted from N+1.
- Reset values: `dout`=0, `tx_valid`=0, `tx_data`=0, both FIFOs empty, ERR=0.
- A reset asserted mid-operation clears the FIFOs immediately; in-flight bytes are lost.

## Configuration
`MMIO_UART_ERR_EN`:
- Defined:
  - ERR[15:0] = RX overflow count; ERR[31:16] = TX full-drop count.
  - Both counters saturate at 16'hFFFF.
  - Any effective write to 0xC clears both counters.
- Undefined: ERR reads 0, writes are ignored, and no counter flops are built.

## Structure
- Shared package `mmio_uart_pkg`: register offset localparams (`OFF_STATUS`, `OFF_RXDATA`, `OFF_TXDATA`, `OFF_ERR`) and STATUS bit-index constants.
- One sub-module, `sync_fifo`, instantiated twice:
  - Parameters `WIDTH`, `DEPTH`.
  - Ports: push, pop, din, dout, full, empty, count.
  - Same async active-high reset.
  - Supports push-while-full when pop is asserted.

## Test plan
- Reset, then read 0x0 → `dout`=32'h0010_0001 (TX_DEPTH=16: 16 free, TX not full, RX empty).
- Inject bytes 0x41, 0x42 on `rx_valid` → STATUS bit1=1 and occupancy=2. Read 0x4 twice → 0x41 then 0x42. A third read → 0 and occupancy stays 0.
- Hold `tx_ready`=0 and write 17 bytes (0x00–0x10) → the last is dropped. ERR=32'h0001_0000 with `MMIO_UART_ERR_EN`, else 0. Release `tx_ready` → 0x00–0x0F emerge in order.
- Fill RX with 16 bytes, then drive `rx_valid` together with an effective RXDATA read → the new byte is accepted, no overflow, and occupancy stays 16. Drive `rx_valid` again without a read → ERR[15:0] increments.
- Hold `stall`=1 during an RXDATA read and a TXDATA write → no pop, no push, `dout` unchanged. Repeat with `stall`=0 → both take effect.
- Assert `rst` with 5 bytes in each FIFO → `tx_valid` drops to 0 at once. STATUS after release = 32'h0010_0001.

Source files
------------

// File: rtl/mmio_uart_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : mmio_uart_pkg
//  Description : Register offsets, register-select encoding and STATUS bit
//                positions shared by the MMIO UART FIFO front end.
//  Revision    : 1.0 - initial release
// ============================================================================
package mmio_uart_pkg;

    // Byte offsets of the four registers inside the 16-byte window
    localparam logic [3:0] OFF_STATUS = 4'h0;
    localparam logic [3:0] OFF_RXDATA = 4'h4;
    localparam logic [3:0] OFF_TXDATA = 4'h8;
    localparam logic [3:0] OFF_ERR    = 4'hC;

    // Register select, decoded from the word index addr[3:2]
    typedef enum logic [1:0] {
        SEL_STATUS = OFF_STATUS[3:2],
        SEL_RXDATA = OFF_RXDATA[3:2],
        SEL_TXDATA = OFF_TXDATA[3:2],
        SEL_ERR    = OFF_ERR[3:2]
    } reg_sel_t;

    // STATUS register bit positions
    localparam int ST_TX_NOT_FULL  = 0;
    localparam int ST_RX_NOT_EMPTY = 1;
    localparam int ST_RX_OCC_LSB   = 8;
    localparam int ST_TX_FREE_LSB  = 16;
    localparam int ST_FIELD_W      = 8;

endpackage : mmio_uart_pkg
`default_nettype wire

// File: rtl/sync_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : sync_fifo
//  Description : Single-clock FIFO with occupancy count. A push to a full
//                FIFO is accepted when a pop happens in the same cycle.
//                Read data is the combinational head entry.
//  Revision    : 1.0 - initial release
// ============================================================================
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         din,
    output logic [WIDTH-1:0]         dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [CW-1:0]    r_count;
    logic             w_do_pop;
    logic             w_do_push;

    assign full      = (r_count == DEPTH_C);
    assign empty     = (r_count == '0);
    assign count     = r_count;
    assign dout      = r_mem[r_rd_ptr];
    assign w_do_pop  = pop && !empty;
    assign w_do_push = push && (!full || w_do_pop);

    // Storage array: cleared on reset so the head reads as zero when empty
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else if (w_do_push) begin
            r_mem[r_wr_ptr] <= din;
        end
    end

    // Pointers wrap naturally modulo DEPTH; count tracks net push/pop
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule : sync_fifo
`default_nettype wire

// File: rtl/mmio_uart_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : mmio_uart_fifo
//  Description : Memory-mapped UART front end on the data-memory bus.
//                STATUS / RXDATA / TXDATA / ERR registers at BASE_ADDR,
//                RX and TX byte FIFOs between the CPU and the UART.
//                Optional feature macro: MMIO_UART_ERR_EN builds saturating
//                RX-overflow and TX-drop counters behind the ERR register.
//  Revision    : 1.0 - initial release
// ============================================================================
module mmio_uart_fifo
    import mmio_uart_pkg::*;
#(
    parameter int          RX_DEPTH  = 16,
    parameter int          TX_DEPTH  = 16,
    parameter logic [31:0] BASE_ADDR = 32'h8000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] addr,
    input  logic [3:0]  we,
    input  logic        re,
    input  logic [31:0] din,
    input  logic        stall,
    output logic [31:0] dout,
    output logic        hit,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    output logic [7:0]  tx_data,
    output logic        tx_valid,
    input  logic        tx_ready
);

    localparam int RX_CW = $clog2(RX_DEPTH) + 1;
    localparam int TX_CW = $clog2(TX_DEPTH) + 1;
    localparam logic [TX_CW-1:0] TX_DEPTH_C = TX_CW'(TX_DEPTH);

    // Bus decode
    reg_sel_t   w_sel;
    logic       w_access;
    logic       w_is_wr;
    logic       w_wr;
    logic       w_rd;
    logic       w_rd_cycle;

    // FIFO connections
    logic [7:0]       w_rx_head;
    logic             w_rx_full;
    logic             w_rx_empty;
    logic [RX_CW-1:0] w_rx_count;
    logic             w_rx_push;
    logic             w_rx_pop;
    logic             w_tx_full;
    logic             w_tx_empty;
    logic [TX_CW-1:0] w_tx_count;
    logic             w_tx_wr;
    logic             w_tx_push;
    logic             w_tx_pop;

    // Error events and read path
    logic             w_rx_ovf;
    logic             w_tx_drop;
    logic [31:0]      w_err_word;
    logic [31:0]      w_status;
    logic [31:0]      w_rd_data;
    logic [31:0]      r_dout;

    // Byte-lane bits of addr and upper din bits carry no meaning here
    logic unused_bits;
    assign unused_bits = ^{addr[1:0], din[31:8]};

    assign hit        = (addr[31:4] == BASE_ADDR[31:4]);
    assign w_sel      = reg_sel_t'(addr[3:2]);
    assign w_access   = hit && !stall;
    assign w_is_wr    = |we;
    assign w_wr       = w_access && w_is_wr;
    assign w_rd_cycle = w_access && re;
    assign w_rd       = w_rd_cycle && !w_is_wr;

    // RX: pop only on an effective RXDATA read of a non-empty FIFO; an
    // incoming byte may land in a full FIFO when that pop frees a slot.
    assign w_rx_pop  = w_rd && (w_sel == SEL_RXDATA) && !w_rx_empty;
    assign w_rx_push = rx_valid && (!w_rx_full || w_rx_pop);
    assign w_rx_ovf  = rx_valid && !w_rx_push;

    // TX: UART drains on handshake; CPU push to full succeeds with a pop
    assign tx_valid  = !w_tx_empty;
    assign w_tx_pop  = tx_valid && tx_ready;
    assign w_tx_wr   = w_wr && (w_sel == SEL_TXDATA);
    assign w_tx_push = w_tx_wr && (!w_tx_full || w_tx_pop);
    assign w_tx_drop = w_tx_wr && !w_tx_push;

    sync_fifo #(
        .WIDTH (8),
        .DEPTH (RX_DEPTH)
    ) u_rx_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (w_rx_push),
        .pop   (w_rx_pop),
        .din   (rx_data),
        .dout  (w_rx_head),
        .full  (w_rx_full),
        .empty (w_rx_empty),
        .count (w_rx_count)
    );

    sync_fifo #(
        .WIDTH (8),
        .DEPTH (TX_DEPTH)
    ) u_tx_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (w_tx_push),
        .pop   (w_tx_pop),
        .din   (din[7:0]),
        .dout  (tx_data),
        .full  (w_tx_full),
        .empty (w_tx_empty),
        .count (w_tx_count)
    );

`ifdef MMIO_UART_ERR_EN
    logic [15:0] r_err_rx;
    logic [15:0] r_err_tx;
    logic        w_err_clr;

    assign w_err_clr  = w_wr && (w_sel == SEL_ERR);
    assign w_err_word = {r_err_tx, r_err_rx};

    // Saturating error counters; a CPU write to ERR clears both
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_err_rx <= '0;
            r_err_tx <= '0;
        end else if (w_err_clr) begin
            r_err_rx <= '0;
            r_err_tx <= '0;
        end else begin
            if (w_rx_ovf && (r_err_rx != 16'hFFFF)) begin
                r_err_rx <= r_err_rx + 16'd1;
            end
            if (w_tx_drop && (r_err_tx != 16'hFFFF)) begin
                r_err_tx <= r_err_tx + 16'd1;
            end
        end
    end
`else
    logic unused_err;
    assign unused_err = w_rx_ovf ^ w_tx_drop;
    assign w_err_word = '0;
`endif

    // STATUS reflects FIFO state before this cycle's push/pop
    always_comb begin
        w_status = '0;
        w_status[ST_TX_NOT_FULL]  = !w_tx_full;
        w_status[ST_RX_NOT_EMPTY] = !w_rx_empty;
        w_status[ST_RX_OCC_LSB +: ST_FIELD_W]  = ST_FIELD_W'(w_rx_count);
        w_status[ST_TX_FREE_LSB +: ST_FIELD_W] = ST_FIELD_W'(TX_DEPTH_C - w_tx_count);
    end

    // Register read multiplexer; RXDATA returns the pre-pop head
    always_comb begin
        w_rd_data = '0;
        case (w_sel)
            SEL_STATUS: w_rd_data = w_status;
            SEL_RXDATA: w_rd_data = w_rx_empty ? 32'd0 : {24'd0, w_rx_head};
            SEL_TXDATA: w_rd_data = '0;
            SEL_ERR:    w_rd_data = w_err_word;
            default:    w_rd_data = '0;
        endcase
    end

    // Read data register: holds between reads; a write with re returns 0
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_dout <= '0;
        end else if (w_rd_cycle) begin
            r_dout <= w_is_wr ? 32'd0 : w_rd_data;
        end
    end

    assign dout = r_dout;

endmodule : mmio_uart_fifo
`default_nettype wire

// File: tb/tb_mmio_uart_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mmio_uart_fifo
//  Description : Scoreboard bench for mmio_uart_fifo. Reads and TX bytes
//                push expectations into queues; monitors pop and compare
//                when dout is due or a TX handshake occurs.
//                Honours MMIO_UART_ERR_EN for ERR register expectations.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_mmio_uart_fifo;

    localparam logic [31:0] BASE = 32'h8000_0000;
`ifdef MMIO_UART_ERR_EN
    localparam bit ERR_EN = 1'b1;
`else
    localparam bit ERR_EN = 1'b0;
`endif

    logic        clk;
    logic        rst;
    logic [31:0] addr;
    logic [3:0]  we;
    logic        re;
    logic [31:0] din;
    logic        stall;
    logic [31:0] dout;
    logic        hit;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready;

    logic [31:0] exp_q [$];
    logic [7:0]  tx_q  [$];
    logic        rd_flag;
    logic        mon_rd;
    int          n_checks;
    int          n_fail;

    mmio_uart_fifo #(
        .RX_DEPTH  (16),
        .TX_DEPTH  (16),
        .BASE_ADDR (BASE)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .addr     (addr),
        .we       (we),
        .re       (re),
        .din      (din),
        .stall    (stall),
        .dout     (dout),
        .hit      (hit),
        .rx_data  (rx_data),
        .rx_valid (rx_valid),
        .tx_data  (tx_data),
        .tx_valid (tx_valid),
        .tx_ready (tx_ready)
    );

    // 10 ns clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Marks which edge carried a scoreboarded read
    always @(posedge clk or posedge rst) begin
        if (rst) mon_rd <= 1'b0;
        else     mon_rd <= rd_flag;
    end

    // Monitor: compare dout one cycle after a read, and every TX handshake
    always @(negedge clk) begin
        if (mon_rd) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL dout: read response with empty scoreboard, got %h", dout);
            end else begin
                check("dout", dout, exp_q.pop_front());
            end
        end
        if (tx_valid && tx_ready) begin
            if (tx_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL tx_data: unexpected byte %h, expected none", tx_data);
            end else begin
                check("tx_data", {24'd0, tx_data}, {24'd0, tx_q.pop_front()});
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic rd(input logic [3:0] off, input logic [31:0] exp);
        addr    = BASE + {28'd0, off};
        re      = 1'b1;
        rd_flag = 1'b1;
        exp_q.push_back(exp);
        tick();
        re      = 1'b0;
        rd_flag = 1'b0;
    endtask

    task automatic wr(input logic [3:0] off, input logic [31:0] data);
        addr = BASE + {28'd0, off};
        we   = 4'hF;
        din  = data;
        tick();
        we   = 4'h0;
    endtask

    task automatic inject(input logic [7:0] b);
        rx_data  = b;
        rx_valid = 1'b1;
        tick();
        rx_valid = 1'b0;
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        rst      = 1'b1;
        addr     = BASE;
        we       = 4'h0;
        re       = 1'b0;
        din      = '0;
        stall    = 1'b0;
        rx_data  = '0;
        rx_valid = 1'b0;
        tx_ready = 1'b0;
        rd_flag  = 1'b0;

        // Reset values
        repeat (3) tick();
        check("rst_dout", dout, 32'd0);
        check("rst_tx_valid", {31'd0, tx_valid}, 32'd0);
        check("rst_tx_data", {24'd0, tx_data}, 32'd0);
        rst = 1'b0;
        tick();

        // Address decode window
        addr = BASE + 32'hC; #1;
        check("hit_top", {31'd0, hit}, 32'd1);
        addr = BASE + 32'h10; #1;
        check("hit_above", {31'd0, hit}, 32'd0);
        addr = BASE - 32'h1; #1;
        check("hit_below", {31'd0, hit}, 32'd0);

        rd(4'h0, 32'h0010_0001);

        // RX path: two bytes, read out in order, then empty read
        inject(8'h41);
        inject(8'h42);
        rd(4'h0, 32'h0010_0203);
        rd(4'h4, 32'h0000_0041);
        rd(4'h4, 32'h0000_0042);
        rd(4'h4, 32'h0000_0000);
        rd(4'h0, 32'h0010_0001);

        // TX path: 17 writes with transmitter stalled, last one dropped
        tx_ready = 1'b0;
        for (int i = 0; i < 17; i++) begin
            wr(4'h8, i);
            if (i < 16) tx_q.push_back(8'(i));
        end
        rd(4'h0, 32'h0000_0000);
        rd(4'h8, 32'h0000_0000);
        rd(4'hC, ERR_EN ? 32'h0001_0000 : 32'h0);
        tx_ready = 1'b1;
        for (int k = 0; k < 64 && tx_q.size() != 0; k++) tick();
        check("tx_drain_left", tx_q.size(), 32'd0);
        tick();
        check("tx_valid_idle", {31'd0, tx_valid}, 32'd0);
        tx_ready = 1'b0;
        wr(4'hC, 32'h0);
        rd(4'hC, 32'h0);

        // RX full: push with same-cycle pop is accepted, then overflow
        for (int i = 0; i < 16; i++) inject(8'h50 + 8'(i));
        rd(4'h0, 32'h0010_1003);
        rx_data  = 8'hAA;
        rx_valid = 1'b1;
        rd(4'h4, 32'h0000_0050);
        rx_valid = 1'b0;
        rd(4'h0, 32'h0010_1003);
        inject(8'hBB);
        rd(4'hC, ERR_EN ? 32'h0000_0001 : 32'h0);
        rd(4'h0, 32'h0010_1003);
        for (int i = 1; i < 16; i++) rd(4'h4, 32'h50 + i);
        rd(4'h4, 32'h0000_00AA);
        rd(4'h0, 32'h0010_0001);

        // Stall blocks both a pop and a push
        inject(8'h33);
        stall = 1'b1;
        addr  = BASE + 32'h4;
        re    = 1'b1;
        tick();
        re    = 1'b0;
        wr(4'h8, 32'h77);
        stall = 1'b0;
        check("stall_dout", dout, 32'h0010_0001);
        check("stall_tx_valid", {31'd0, tx_valid}, 32'd0);
        rd(4'h0, 32'h0010_0103);
        rd(4'h4, 32'h0000_0033);
        wr(4'h8, 32'h77);
        tx_q.push_back(8'h77);
        check("tx_valid_latency", {31'd0, tx_valid}, 32'd1);

        // Read and write together: the write wins and dout reads 0
        addr    = BASE + 32'h8;
        we      = 4'h1;
        re      = 1'b1;
        din     = 32'h78;
        rd_flag = 1'b1;
        exp_q.push_back(32'h0);
        tx_q.push_back(8'h78);
        tick();
        we      = 4'h0;
        re      = 1'b0;
        rd_flag = 1'b0;
        rd(4'h0, 32'h000E_0001);

        // Reset mid-operation with five bytes in each FIFO
        for (int i = 0; i < 3; i++) wr(4'h8, 32'h79 + i);
        for (int i = 0; i < 5; i++) inject(8'h60 + 8'(i));
        rd(4'h0, 32'h000B_0503);
        tick();
        rst = 1'b1;
        #1;
        check("rst_async_tx_valid", {31'd0, tx_valid}, 32'd0);
        check("rst_async_dout", dout, 32'd0);
        tx_q.delete();
        repeat (2) tick();
        rst      = 1'b0;
        tx_ready = 1'b1;
        tick();
        rd(4'h0, 32'h0010_0001);
        rd(4'hC, 32'h0);
        repeat (3) tick();

        check("scoreboard_left", exp_q.size(), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    // Global watchdog
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule : tb_mmio_uart_fifo
`default_nettype wire
